// File: rtl/conv_pkg.sv
// conv_pkg: FSM state and band geometry helpers shared by the convolution datapath.
package conv_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  function automatic int rows_per_ch(input int k, input int p);
    return p - k + 1;
  endfunction
  function automatic int reqs_per_frame(input int k, input int p, input int c);
    return (p - k + 1) * c;
  endfunction
  function automatic int beats_per_band(input int k, input int p);
    return k * p;
  endfunction
  function automatic int addr_w(input int c, input int p);
    return (c * p * p > 1) ? $clog2(c * p * p) : 1;
  endfunction
endpackage

// File: rtl/pic_rd_pipe.sv
// pic_rd_pipe: one-stage read pipeline; flush drops the beat currently in flight.
module pic_rd_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] pic,
  output logic             pic_valid
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pic_valid <= 1'b0;
      pic <= '0;
    end else begin
      pic_valid <= en && !flush;
      if (en && !flush) pic <= data;
    end
endmodule

// File: rtl/pic_feeder.sv
// pic_feeder: streams one kernel-high band of one channel per need_pic pulse, row outer / channel inner.
module pic_feeder
  import conv_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int kernel_size = 5,
  parameter int pic_size    = 28,
  parameter int channel     = 3,
  parameter int ADDR_W      = addr_w(channel, pic_size)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              conv_start,
  input  logic              need_pic,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic [WIDTH-1:0]  pic,
  output logic              pic_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              req_overflow
);
  localparam int R  = rows_per_ch(kernel_size, pic_size);
  localparam int B  = beats_per_band(kernel_size, pic_size);
  localparam int PP = pic_size * pic_size;
  localparam int RW = R > 1 ? $clog2(R) : 1;
  localparam int CW = channel > 1 ? $clog2(channel) : 1;
  localparam int BW = B > 1 ? $clog2(B) : 1;
  state_t state;
  logic [BW-1:0] beat_cnt;
  logic [RW-1:0] row, nxt_row;
  logic [CW-1:0] ch, nxt_ch;
  logic pending, last_beat, wrap_frame;
  function automatic logic [ADDR_W-1:0] band_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return ADDR_W'(32'(c) * PP + 32'(r) * pic_size);
  endfunction
  always_comb begin
    last_beat = state == BURST && beat_cnt == BW'(B - 1);
    wrap_frame = ch == CW'(channel - 1) && row == RW'(R - 1);
    nxt_ch = ch == CW'(channel - 1) ? '0 : ch + 1'b1;
    nxt_row = ch != CW'(channel - 1) ? row : wrap_frame ? '0 : row + 1'b1;
  end
  assign mem_rd_en = state == BURST;
  assign busy = state == BURST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      beat_cnt <= '0;
      mem_rd_addr <= '0;
      row <= '0;
      ch <= '0;
      pending <= 1'b0;
      req_overflow <= 1'b0;
      frame_done <= 1'b0;
    end else if (conv_start) begin
      state <= need_pic ? BURST : IDLE;
      beat_cnt <= '0;
      mem_rd_addr <= '0;
      row <= '0;
      ch <= '0;
      pending <= 1'b0;
      req_overflow <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_beat && wrap_frame;
      if (state == IDLE) begin
        if (need_pic) begin
          state <= BURST;
          beat_cnt <= '0;
          mem_rd_addr <= band_addr(row, ch);
        end
      end else if (last_beat) begin
        row <= nxt_row;
        ch <= nxt_ch;
        beat_cnt <= '0;
        // a request landing on the last beat becomes the new pending one
        pending <= pending && need_pic;
        if (pending || need_pic) mem_rd_addr <= band_addr(nxt_row, nxt_ch);
        else state <= IDLE;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
        mem_rd_addr <= mem_rd_addr + 1'b1;
        if (need_pic) begin
          if (pending) req_overflow <= 1'b1;
          pending <= 1'b1;
        end
      end
    end
  pic_rd_pipe #(.WIDTH(WIDTH)) u_pipe (
    .clk(clk),
    .rst_n(rst_n),
    .flush(conv_start),
    .en(mem_rd_en),
    .data(mem_rd_data),
    .pic(pic),
    .pic_valid(pic_valid)
  );
endmodule

// File: tb/tb_pic_feeder.sv
// tb_pic_feeder: scoreboard bench; stimulus queues expected pixels, a negedge monitor checks them.
module tb_pic_feeder;
  localparam int W = 16, K = 5, P = 28, C = 3, AW = 12;
  localparam int B = K * P, N = (P - K + 1) * C;
  logic clk = 1'b0, rst_n = 1'b0, conv_start = 1'b0, need_pic = 1'b0;
  logic mem_rd_en, pic_valid, busy, frame_done, req_overflow;
  logic [AW-1:0] mem_rd_addr;
  logic [W-1:0] mem_rd_data = '0, pic;
  logic [W:0] sb[$];
  logic [W:0] exp_e;
  int checks = 0, errors = 0, cyc = 0, nb = 0, n = 0;
  int vcnt = 0, vfirst = -1, vlast = -1, fd_cnt = 0;

  pic_feeder #(.WIDTH(W), .kernel_size(K), .pic_size(P), .channel(C)) dut (
    .clk(clk), .rst_n(rst_n), .conv_start(conv_start), .need_pic(need_pic),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .pic(pic), .pic_valid(pic_valid), .busy(busy), .frame_done(frame_done),
    .req_overflow(req_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // every address maps to a distinct pixel so a wrong address shows up as a wrong pic
  function automatic logic [W-1:0] pix(input logic [AW-1:0] a);
    return {4'hA, a};
  endfunction

  always @(negedge clk) if (mem_rd_en) mem_rd_data <= pix(mem_rd_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (pic_valid) begin
      vcnt++;
      if (vfirst < 0) vfirst = cyc;
      vlast = cyc;
      if (frame_done) fd_cnt++;
      if (sb.size() == 0) chk("unexpected_beat", pic_valid, 0);
      else begin
        exp_e = sb.pop_front();
        chk("pic", pic, exp_e[W:1]);
        chk("frame_done", frame_done, exp_e[0]);
      end
    end else if (frame_done) chk("frame_done_no_valid", frame_done, 0);
  end

  task automatic push_band();
    int c = nb % C, r = nb / C;
    int s = c * P * P + r * P;
    for (int i = 0; i < B; i++) sb.push_back({pix(AW'(s + i)), nb == N - 1 && i == B - 1});
    nb = (nb + 1) % N;
  endtask

  task automatic pulse();
    need_pic = 1'b1;
    @(posedge clk); #1;
    need_pic = 1'b0;
  endtask

  task automatic req();
    push_band();
    pulse();
  endtask

  task automatic start();
    conv_start = 1'b1;
    @(posedge clk); #1;
    conv_start = 1'b0;
    sb.delete();
    nb = 0;
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy && k < lim) begin
      @(posedge clk); #1;
      k++;
    end
    chk("idle_timeout", busy, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_rd_addr, 0);
    chk({tag, "_pic"}, pic, 0);
    chk({tag, "_valid"}, pic_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_ovf"}, req_overflow, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    start();
    // band 0 latency and busy window
    req();
    chk("s1_en", mem_rd_en, 1);
    chk("s1_addr0", mem_rd_addr, 0);
    chk("s1_busy", busy, 1);
    chk("s1_no_early_valid", pic_valid, 0);
    @(posedge clk); #1;
    chk("s1_first_valid", pic_valid, 1);
    repeat (138) @(posedge clk);
    #1;
    chk("s1_busy_last", busy, 1);
    chk("s1_addr_last", mem_rd_addr, 139);
    @(posedge clk); #1;
    chk("s1_busy_drop", busy, 0);
    chk("s1_last_valid", pic_valid, 1);
    @(posedge clk); #1;
    chk("s1_valid_end", pic_valid, 0);
    chk("s1_pic_hold", pic, pix(139));
    chk("s1_drained", sb.size(), 0);
    // bands 1..3
    req();
    chk("s2_band1_addr", mem_rd_addr, 784);
    wait_idle(300);
    req();
    wait_idle(300);
    req();
    chk("s2_band3_addr", mem_rd_addr, 28);
    wait_idle(300);
    chk("s2_drained", sb.size(), 0);
    // full frame back-to-back
    start();
    vcnt = 0; vfirst = -1; vlast = -1; fd_cnt = 0;
    req();
    repeat (20) @(posedge clk);
    #1;
    for (int k = 1; k < N; k++) begin
      req();
      repeat (139) @(posedge clk);
      #1;
    end
    wait_idle(400);
    chk("s3_valid_count", vcnt, N * B);
    chk("s3_valid_span", vlast - vfirst + 1, N * B);
    chk("s3_frame_done_once", fd_cnt, 1);
    chk("s3_last_pic", pic, pix(2351));
    chk("s3_no_overflow", req_overflow, 0);
    chk("s3_drained", sb.size(), 0);
    // overflow
    start();
    req();
    repeat (10) @(posedge clk);
    #1;
    req();
    repeat (10) @(posedge clk);
    #1;
    pulse();
    chk("s4_overflow", req_overflow, 1);
    wait_idle(600);
    chk("s4_overflow_sticky", req_overflow, 1);
    chk("s4_drained", sb.size(), 0);
    start();
    chk("s4_overflow_cleared", req_overflow, 0);
    // abort mid-band
    for (int k = 0; k < 5; k++) begin
      req();
      wait_idle(300);
    end
    req();
    n = 0;
    while (!(mem_rd_en && mem_rd_addr == AW'(1646)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s5_reach_beat50", mem_rd_addr, 1646);
    start();
    chk("s5_valid_drop", pic_valid, 0);
    chk("s5_idle", busy, 0);
    chk("s5_pic_hold", pic, pix(1645));
    req();
    chk("s5_restart_addr", mem_rd_addr, 0);
    wait_idle(300);
    chk("s5_drained", sb.size(), 0);
    // asynchronous reset mid-burst
    start();
    req();
    repeat (30) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("s6_async");
    sb.delete();
    nb = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("s6_quiet", pic_valid, 0);
    req();
    chk("s6_restart_addr", mem_rd_addr, 0);
    wait_idle(300);
    chk("s6_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pic_feeder.md
# pic_feeder

Picture-side responder for the convolution controller's `need_pic` request. Each single-cycle `need_pic` pulse makes the block stream one input band into the conv engine over `pic`/`pic_valid`, one pixel per cycle. A band is `kernel_size` full picture rows of one channel, read from an external synchronous-read picture memory. The block walks output rows and channels itself, so the requester only pulses `need_pic`.

## Interface
- `WIDTH`, 8, pixel width.
- `kernel_size`, 5, kernel height in rows.
- `pic_size`, 28, picture side length in pixels.
- `channel`, 3, number of input channels.
- `ADDR_W`, `$clog2(channel*pic_size*pic_size)`, memory address width (derived).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `conv_start` in 1: pulse; restarts the band sequence at channel 0, row 0.
- `need_pic` in 1: pulse; requests the next band.
- `mem_rd_en` out 1: memory read strobe.
- `mem_rd_addr` out `ADDR_W`: memory read address.
- `mem_rd_data` in `WIDTH`: read data, valid exactly 1 cycle after `mem_rd_en`.
- `pic` out `WIDTH`: pixel to the conv engine.
- `pic_valid` out 1: `pic` is valid this cycle.
- `busy` out 1: a burst is active or a request is pending.
- `frame_done` out 1: 1-cycle pulse on the last pixel of the last band of a frame.
- `req_overflow` out 1: sticky error; cleared only by reset or `conv_start`.

## Operation
- Derived constants:
  - Rows per channel R = `pic_size-kernel_size+1`.
  - Requests per frame N = R*`channel`.
  - Beats per band B = `kernel_size*pic_size`.
- Band order: output row outer, channel inner.
  - Request index n maps to `ch = n % channel` and `row = n / channel`.
- A band is contiguous in memory.
  - Start address = `ch*pic_size*pic_size + row*pic_size`.
  - Addresses run start .. start+B-1, incrementing by 1.
- FSM states:
  - IDLE: no burst active.
  - BURST: issue one read per cycle; `beat_cnt` runs 0..B-1.
  - BURST -> IDLE after beat B-1, unless a request is pending.
- Request handling:
  - `need_pic` in IDLE starts a burst.
  - `need_pic` in BURST sets a 1-deep pending flag.
  - `need_pic` while pending is already set sets `req_overflow`; the extra request is dropped.
  - On the last beat with pending set, the next band starts the following cycle (back-to-back) and pending clears.
  - `need_pic` coincident with the last beat counts as pending, not overflow.
- Sequencing:
  - After each completed band, advance `ch`.
  - On `ch` wrap to 0, advance `row`.
  - After band N-1, `row` and `ch` wrap to 0 and `frame_done` pulses, aligned with the last `pic_valid`.
- `conv_start` behaviour:
  - Clears `row`, `ch`, pending, `req_overflow` and the read pipeline.
  - Aborts any burst: the in-flight beat is dropped and `pic_valid` is 0 the next cycle.
  - Returns to IDLE.
  - `conv_start` and `need_pic` in the same cycle: `conv_start` wins, then the request starts band 0 of the new frame.
- `pic` is registered `mem_rd_data` and holds its last value when `pic_valid` is low.

## Timing
- `need_pic` sampled high at edge t:
  - `mem_rd_en` and `mem_rd_addr` = start at t+1.
  - `pic_valid` first high at t+2.
  - B consecutive valid cycles with no gaps.
- Back-to-back bands give N*B continuous `pic_valid` cycles when requests keep pending.
- `busy` is high from t+1 through the cycle of the last `mem_rd_en`.
- Reset values: all outputs 0; `mem_rd_addr` = 0; state IDLE; counters 0.
- Reset mid-burst aborts immediately (asynchronous); no further beats are produced.

## Structure
- Shared package `conv_pkg` holds:
  - the FSM state enum (IDLE, BURST);
  - constant functions for R, N and B;
  - the `ADDR_W` function, shared with the convolution control side.
- One sub-module, `pic_rd_pipe`: the 1-stage valid/data pipeline with flush. It registers `mem_rd_en` to `pic_valid` and `mem_rd_data` to `pic`.

## Test plan
All scenarios use defaults K=5, P=28, C=3, so R=24, N=72, B=140.
1. Reset, `conv_start`, one `need_pic` at cycle 10 -> addresses 0..139 at cycles 11..150; `pic_valid` cycles 12..151; `busy` drops after cycle 150.
2. Second and fourth requests -> band 1 reads 784..923 (ch1, row0); band 3 reads 28..167 (ch0, row1).
3. 72 requests, each issued during the previous burst -> 10080 contiguous `pic_valid` cycles; last band reads 2212..2351; `frame_done` pulses once, on the last beat.
4. Two extra `need_pic` pulses during one burst -> `req_overflow`=1 and stays set; exactly one extra band is streamed; `conv_start` clears `req_overflow`.
5. `conv_start` at beat 50 of band 5 -> `pic_valid` low the next cycle; the next `need_pic` reads 0..139.
6. `rst_n` low mid-burst -> all outputs 0 asynchronously; after release, `need_pic` streams band 0.
